// File: rtl/iq_mixer_decim_if.sv
// Sample-stream bundle for iq_mixer_decim: ADC/NCO input samples and the decimated I/Q output.
// The DUT side is the slave modport and the driving/consuming side is the master modport.
interface iq_mixer_decim_if #(
    parameter int unsigned DATA_W = 16
) ();
    logic signed [DATA_W-1:0] adc_i;
    logic                     adc_valid_i;
    logic signed [DATA_W-1:0] sin_i;
    logic signed [DATA_W-1:0] cos_i;
    logic                     nco_valid_i;
    logic signed [DATA_W-1:0] i_o;
    logic signed [DATA_W-1:0] q_o;
    logic                     valid_o;
    logic                     ready_i;

    modport slave (
        input  adc_i,
        input  adc_valid_i,
        input  sin_i,
        input  cos_i,
        input  nco_valid_i,
        output i_o,
        output q_o,
        output valid_o,
        input  ready_i
    );

    modport master (
        output adc_i,
        output adc_valid_i,
        output sin_i,
        output cos_i,
        output nco_valid_i,
        input  i_o,
        input  q_o,
        input  valid_o,
        output ready_i
    );
endinterface

// File: rtl/iq_mixer_decim.sv
// Complex mixer followed by an integrate-and-dump decimator.
// Pipeline: products (edge N) -> accumulate (N+1) -> round/saturate (N+2) -> output reg (N+3).
module iq_mixer_decim #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ACC_W  = 2 * DATA_W + 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    iq_mixer_decim_if.slave   bus,
    input  logic              enable_i,
    input  logic [7:0]        decim_i,
    input  logic [4:0]        shift_i,
    input  logic              clear_i,
    output logic              overflow_o
);
    localparam int unsigned PROD_W = 2 * DATA_W;

    // Saturation bounds expressed at ACC_W+1 bits so rounding never wraps.
    localparam logic signed [ACC_W:0] SatMax = {{(ACC_W + 2 - DATA_W){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SatMin = {{(ACC_W + 2 - DATA_W){1'b1}}, {(DATA_W - 1){1'b0}}};

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                   state_q;
    logic [7:0]               r_q;
    logic [4:0]               shift_q;
    logic [7:0]               cnt_q;

    logic                     accept;
    logic                     flush;
    logic                     frame_end;
    logic [8:0]               r_eff;
    logic [8:0]               cnt_inc;

    logic signed [PROD_W-1:0] prod_i;
    logic signed [PROD_W-1:0] prod_q;
    logic signed [PROD_W-1:0] p_i_q;
    logic signed [PROD_W-1:0] p_q_q;
    logic                     s1_valid_q;
    logic                     s1_first_q;
    logic                     s1_last_q;
    logic [4:0]               s1_shift_q;

    logic signed [ACC_W-1:0]  acc_i_q;
    logic signed [ACC_W-1:0]  acc_q_q;
    logic signed [ACC_W-1:0]  ext_i;
    logic signed [ACC_W-1:0]  ext_q;
    logic                     acc_done_q;
    logic [4:0]               acc_shift_q;

    logic [DATA_W:0]          rs_i;
    logic [DATA_W:0]          rs_q;
    logic signed [DATA_W-1:0] res_i_q;
    logic signed [DATA_W-1:0] res_q_q;
    logic                     res_valid_q;
    logic                     res_sat_q;

    logic signed [DATA_W-1:0] out_i_q;
    logic signed [DATA_W-1:0] out_q_q;
    logic                     out_valid_q;
    logic                     out_stall;
    logic                     ovf_set;
    logic                     overflow_q;

    // Round-half-up by 2^(sh-1), arithmetic shift, then clamp; returns {saturated, value}.
    function automatic logic [DATA_W:0] round_sat(input logic signed [ACC_W-1:0] acc,
                                                  input logic [4:0] sh);
        logic signed [ACC_W:0] rnd;
        logic signed [ACC_W:0] sum;
        logic signed [ACC_W:0] val;
        logic [DATA_W:0]       res;
        rnd = '0;
        if (sh != 5'd0) begin
            rnd = {{ACC_W{1'b0}}, 1'b1} << (sh - 5'd1);
        end
        sum = {acc[ACC_W-1], acc} + rnd;
        val = sum >>> sh;
        if (val > SatMax) begin
            res = {1'b1, 1'b0, {(DATA_W - 1){1'b1}}};
        end else if (val < SatMin) begin
            res = {1'b1, 1'b1, {(DATA_W - 1){1'b0}}};
        end else begin
            res = {1'b0, val[DATA_W-1:0]};
        end
        return res;
    endfunction

    // Sample acceptance, frame-boundary detection and mixer products.
    always_comb begin
        accept    = bus.adc_valid_i & bus.nco_valid_i & enable_i & (state_q == StRun);
        // Leaving or sitting in IDLE throws away the partial frame and in-flight products.
        flush     = (state_q != StRun) | ~enable_i;
        r_eff     = (r_q == 8'd0) ? 9'd256 : {1'b0, r_q};
        cnt_inc   = {1'b0, cnt_q} + 9'd1;
        frame_end = accept & (cnt_inc == r_eff);
        prod_i    = PROD_W'(bus.adc_i) * PROD_W'(bus.cos_i);
        prod_q    = -(PROD_W'(bus.adc_i) * PROD_W'(bus.sin_i));
        ext_i     = {{(ACC_W - PROD_W){p_i_q[PROD_W-1]}}, p_i_q};
        ext_q     = {{(ACC_W - PROD_W){p_q_q[PROD_W-1]}}, p_q_q};
        rs_i      = round_sat(acc_i_q, acc_shift_q);
        rs_q      = round_sat(acc_q_q, acc_shift_q);
        out_stall = out_valid_q & ~bus.ready_i;
        ovf_set   = res_valid_q & (res_sat_q | out_stall);
    end

    // Run/stop FSM, sample counter and per-frame latching of ratio and shift.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            r_q     <= 8'd0;
            shift_q <= 5'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (enable_i) begin
                        state_q <= StRun;
                        r_q     <= decim_i;
                        shift_q <= shift_i;
                    end
                end
                StRun: begin
                    if (!enable_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
            if (flush) begin
                cnt_q <= 8'd0;
            end else if (accept) begin
                cnt_q <= frame_end ? 8'd0 : cnt_inc[7:0];
            end
            if (frame_end) begin
                r_q     <= decim_i;
                shift_q <= shift_i;
            end
        end
    end

    // Stage 1: register full-precision products with their frame position.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_shift_q <= 5'd0;
            p_i_q      <= '0;
            p_q_q      <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                p_i_q      <= prod_i;
                p_q_q      <= prod_q;
                s1_first_q <= (cnt_q == 8'd0);
                s1_last_q  <= frame_end;
                // Old shift_q here: a boundary reload on this edge belongs to the next frame.
                s1_shift_q <= shift_q;
            end
        end
    end

    // Stage 2: integrate; the first product of a frame overwrites the accumulator.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_i_q     <= '0;
            acc_q_q     <= '0;
            acc_done_q  <= 1'b0;
            acc_shift_q <= 5'd0;
        end else begin
            acc_done_q <= s1_valid_q & s1_last_q & ~flush;
            if (s1_valid_q && !flush) begin
                acc_i_q <= s1_first_q ? ext_i : acc_i_q + ext_i;
                acc_q_q <= s1_first_q ? ext_q : acc_q_q + ext_q;
                if (s1_last_q) begin
                    acc_shift_q <= s1_shift_q;
                end
            end
        end
    end

    // Stage 3: dump the finished frame through rounding and saturation.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            res_valid_q <= 1'b0;
            res_sat_q   <= 1'b0;
            res_i_q     <= '0;
            res_q_q     <= '0;
        end else begin
            res_valid_q <= acc_done_q;
            if (acc_done_q) begin
                res_i_q   <= rs_i[DATA_W-1:0];
                res_q_q   <= rs_q[DATA_W-1:0];
                res_sat_q <= rs_i[DATA_W] | rs_q[DATA_W];
            end
        end
    end

    // Output register: hold under backpressure, drop newcomers that would overwrite it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_i_q     <= '0;
            out_q_q     <= '0;
        end else if (res_valid_q && !out_stall) begin
            out_valid_q <= 1'b1;
            out_i_q     <= res_i_q;
            out_q_q     <= res_q_q;
        end else if (out_valid_q && bus.ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    // Sticky overflow; a set event beats a simultaneous clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overflow_q <= 1'b0;
        end else if (ovf_set) begin
            overflow_q <= 1'b1;
        end else if (clear_i) begin
            overflow_q <= 1'b0;
        end
    end

    assign bus.i_o     = out_i_q;
    assign bus.q_o     = out_q_q;
    assign bus.valid_o = out_valid_q;
    assign overflow_o  = overflow_q;
endmodule

// File: tb/tb_iq_mixer_decim.sv
// Directed scoreboard bench for iq_mixer_decim.
module tb_iq_mixer_decim;
    localparam int DW = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] decim = 8'd4;
    logic [4:0] shift = 5'd14;
    logic       ovf;

    iq_mixer_decim_if #(.DATA_W(DW)) bus ();

    iq_mixer_decim #(.DATA_W(DW), .ACC_W(2 * DW + 8)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .bus        (bus),
        .enable_i   (enable),
        .decim_i    (decim),
        .shift_i    (shift),
        .clear_i    (clear),
        .overflow_o (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic signed [15:0] i;
        logic signed [15:0] q;
        int                 cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   passed = 0;
    int   fails = 0;
    int   n_xfer = 0;

    // Reference model state
    longint m_acc_i, m_acc_q;
    int     m_cnt, m_r, m_sh;
    bit     m_ovf = 1'b0;

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int eff(input logic [7:0] d);
        return (d == 8'd0) ? 256 : int'(d);
    endfunction

    function automatic logic signed [15:0] model_rs(input longint acc, input int sh,
                                                    output bit sat);
        longint v;
        v = (sh == 0) ? acc : ((acc + (64'sd1 <<< (sh - 1))) >>> sh);
        sat = 1'b1;
        if (v > 32767) return 16'h7fff;
        if (v < -32768) return 16'h8000;
        sat = 1'b0;
        return 16'(v);
    endfunction

    task automatic model_clear();
        m_cnt = 0;
        m_acc_i = 0;
        m_acc_q = 0;
    endtask

    task automatic start_run();
        enable = 1'b1;
        @(posedge clk);
        #1;
        m_r = eff(decim);
        m_sh = int'(shift);
        model_clear();
    endtask

    task automatic stop_run();
        repeat (5) @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
    endtask

    // One accepted sample; at frame close the expected result goes to the scoreboard.
    task automatic sample(input logic signed [15:0] adc, input logic signed [15:0] sn,
                          input logic signed [15:0] cs, input bit drop, input bit lat);
        exp_t e;
        bit   si, sq;
        bus.adc_i = adc;
        bus.sin_i = sn;
        bus.cos_i = cs;
        bus.adc_valid_i = 1'b1;
        bus.nco_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.adc_valid_i = 1'b0;
        bus.nco_valid_i = 1'b0;
        m_acc_i += longint'(adc) * longint'(cs);
        m_acc_q -= longint'(adc) * longint'(sn);
        m_cnt++;
        if (m_cnt == m_r) begin
            e.i = model_rs(m_acc_i, m_sh, si);
            e.q = model_rs(m_acc_q, m_sh, sq);
            e.cyc = lat ? cyc + 3 : 0;
            if (si || sq || drop) m_ovf = 1'b1;
            if (!drop) sb.push_back(e);
            model_clear();
            m_r = eff(decim);
            m_sh = int'(shift);
        end
    endtask

    // A cycle where only the ADC side is valid: must not be accepted.
    task automatic idle_adc_only();
        bus.adc_i = 16'sd12345;
        bus.adc_valid_i = 1'b1;
        bus.nco_valid_i = 1'b0;
        @(posedge clk);
        #1;
        bus.adc_valid_i = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("drain_pending", sb.size(), 0);
    endtask

    task automatic wait_valid(input int lim);
        int k;
        k = 0;
        while (!bus.valid_o && k < lim) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("wait_valid", bus.valid_o, 1);
    endtask

    // Scoreboard: compare every transfer against the oldest expected result.
    always @(negedge clk) begin
        if (!rst && bus.valid_o && bus.ready_i) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", bus.valid_o, 0);
            end else begin
                mon_e = sb.pop_front();
                n_xfer++;
                chk("i_o", bus.i_o, mon_e.i);
                chk("q_o", bus.q_o, mon_e.q);
                if (mon_e.cyc != 0) chk("latency", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        int base;
        bus.adc_i = '0;
        bus.sin_i = '0;
        bus.cos_i = '0;
        bus.adc_valid_i = 1'b0;
        bus.nco_valid_i = 1'b0;
        bus.ready_i = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_i_o", bus.i_o, 0);
        chk("rst_q_o", bus.q_o, 0);
        chk("rst_valid_o", bus.valid_o, 0);
        chk("rst_overflow", ovf, 0);
        rst = 1'b0;
        bus.ready_i = 1'b1;

        // R=4 cos mixing, 3 frames, one ignored cycle in the middle
        decim = 8'd4;
        shift = 5'd14;
        start_run();
        base = n_xfer;
        for (int k = 0; k < 12; k++) begin
            if (k == 5) idle_adc_only();
            sample(16'sd1000, 16'sd0, 16'sd16384, 1'b0, 1'b1);
        end
        stop_run();
        drain();
        chk("r4_transfers", n_xfer - base, 3);

        // R=1 sin mixing: one result every cycle
        decim = 8'd1;
        start_run();
        for (int k = 0; k < 8; k++) sample(16'sd1000, 16'sd16384, 16'sd0, 1'b0, 1'b1);
        stop_run();
        drain();
        chk("no_overflow_yet", ovf, m_ovf);

        // Saturation sets overflow; clear drops it
        decim = 8'd4;
        start_run();
        for (int k = 0; k < 4; k++) sample(16'sd32767, 16'sd0, 16'sd32767, 1'b0, 1'b1);
        stop_run();
        drain();
        chk("sat_overflow", ovf, m_ovf);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        m_ovf = 1'b0;
        chk("cleared_overflow", ovf, m_ovf);

        // Backpressure across two dumps: hold first, drop second
        bus.ready_i = 1'b0;
        start_run();
        for (int k = 0; k < 4; k++) sample(16'sd1000, 16'sd0, 16'sd16384, 1'b0, 1'b0);
        wait_valid(10);
        for (int k = 0; k < 4; k++) sample(16'sd2000, 16'sd0, 16'sd16384, 1'b1, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        chk("held_i_o", bus.i_o, 4000);
        chk("held_valid", bus.valid_o, 1);
        chk("drop_overflow", ovf, m_ovf);
        bus.ready_i = 1'b1;
        drain();
        chk("valid_after_xfer", bus.valid_o, 0);
        stop_run();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        m_ovf = 1'b0;

        // decim=0 means 256; a mid-frame decim change applies from the next frame
        decim = 8'd0;
        shift = 5'd8;
        start_run();
        base = n_xfer;
        for (int k = 0; k < 10; k++) sample(16'sd100, 16'sd0, 16'sd256, 1'b0, 1'b1);
        decim = 8'd2;
        for (int k = 0; k < 246; k++) sample(16'sd100, 16'sd0, 16'sd256, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) sample(16'sd100, 16'sd0, 16'sd256, 1'b0, 1'b1);
        stop_run();
        drain();
        chk("r256_transfers", n_xfer - base, 3);

        // Enable drop mid-frame discards the partial frame
        decim = 8'd4;
        shift = 5'd14;
        start_run();
        for (int k = 0; k < 2; k++) sample(16'sd3000, 16'sd0, 16'sd16384, 1'b0, 1'b1);
        stop_run();
        start_run();
        for (int k = 0; k < 4; k++) sample(16'sd1000, 16'sd0, 16'sd16384, 1'b0, 1'b1);
        stop_run();
        drain();

        // Reset with an output pending and a partial frame
        bus.ready_i = 1'b0;
        start_run();
        for (int k = 0; k < 4; k++) sample(16'sd1000, 16'sd0, 16'sd16384, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) sample(16'sd3000, 16'sd0, 16'sd16384, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst2_i_o", bus.i_o, 0);
        chk("rst2_q_o", bus.q_o, 0);
        chk("rst2_valid_o", bus.valid_o, 0);
        chk("rst2_overflow", ovf, 0);
        rst = 1'b0;
        sb.delete();
        m_ovf = 1'b0;
        bus.ready_i = 1'b1;
        start_run();
        for (int k = 0; k < 4; k++) sample(16'sd1000, 16'sd0, 16'sd16384, 1'b0, 1'b1);
        stop_run();
        drain();
        chk("final_overflow", ovf, m_ovf);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/iq_mixer_decim.md
IQ_MIXER_DECIM -- requirements
Module: iq_mixer_decim

Interface
REQ-001 Parameter DATA_W, default 16: width of ADC, NCO and output samples (two's complement).
REQ-002 Parameter ACC_W, default 40: accumulator width, equal to 2*DATA_W+8.
REQ-003 clk_i  in  1  sole clock; all logic on its rising edge.
REQ-004 rst_i  in  1  reset, synchronous and active-high.
REQ-005 adc_i  in  DATA_W  signed ADC sample.
REQ-006 adc_valid_i  in  1  adc_i valid this cycle.
REQ-007 sin_i, cos_i  in  DATA_W each  signed NCO outputs, one channel of the upstream NCO.
REQ-008 nco_valid_i  in  1  sin_i/cos_i valid this cycle; one bit of the NCO valid_o bus.
REQ-009 enable_i  in  1  run/stop.
REQ-010 decim_i  in  8  decimation ratio R; 0 means 256.
REQ-011 shift_i  in  5  output right-shift, 0..31.
REQ-012 clear_i  in  1  clears overflow_o.
REQ-013 i_o, q_o  out  DATA_W each  decimated baseband I/Q.
REQ-014 valid_o  out  1  i_o/q_o valid; ready_i  in  1  downstream accepts.
REQ-015 overflow_o  out  1  sticky: a result was dropped or saturated.

Function
REQ-016 The block SHALL accept a sample on every cycle with adc_valid_i & nco_valid_i & enable_i high and FSM in RUN; otherwise the input is ignored with no stall to upstream.
REQ-017 Stage 1 SHALL register full-precision products pI = adc_i*cos_i and pQ = -(adc_i*sin_i), 2*DATA_W bits signed; -32768*-32768 = 2^30 is represented exactly.
REQ-018 Stage 2 SHALL sign-extend the products to ACC_W and add them to accI/accQ; the first product of a frame SHALL load, not add.
REQ-019 FSM states: IDLE, RUN. IDLE->RUN when enable_i=1; RUN->IDLE when enable_i=0; transition on the next edge.
REQ-020 On entering RUN and at every frame boundary, R and shift SHALL be latched from decim_i/shift_i; mid-frame changes SHALL have no effect.
REQ-021 A sample counter SHALL count accepted samples 1..R; the R-th accepted sample closes the frame and the counter wraps to 0 on the same edge.
REQ-022 Dump: result = (acc + 2^(shift-1)) >>> shift (no rounding term when shift=0), then saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; any saturation of I or Q SHALL set overflow_o.
REQ-023 Latency: R-th sample accepted at edge N -> valid_o high with the result after edge N+3; sustained throughput of one sample per clock.
REQ-024 Output handshake: transfer on valid_o & ready_i; i_o/q_o SHALL be stable while valid_o=1 and ready_i=0; valid_o falls after a transfer unless a new result loads on the same edge.
REQ-025 If a result is ready while valid_o=1 and ready_i=0, the new result SHALL be dropped, the held output kept, and overflow_o set.
REQ-026 Simultaneous transfer and new result on one edge SHALL load the new result, with valid_o remaining 1.
REQ-027 clear_i SHALL clear overflow_o on the next edge; a set event on the same edge SHALL win.
REQ-028 enable_i falling mid-frame SHALL discard the partial frame and in-flight products; a pending output SHALL remain until transferred.

Reset
REQ-029 While rst_i=1 at an edge: FSM=IDLE, counter=0, accumulators=0, pipeline valids=0, i_o=0, q_o=0, valid_o=0, overflow_o=0.
REQ-030 Reset mid-frame or with output pending SHALL discard everything; the first frame after reset SHALL start with the first accepted sample.

Verification
REQ-031 adc=1000, cos=16384, sin=0, R=4, shift=14, ready=1 -> i_o=4000, q_o=0, one valid_o pulse per 4 samples, 3-cycle latency.
REQ-032 adc=1000, sin=16384, cos=0, R=1, shift=14 -> q_o=-1000 every cycle, valid_o continuously 1.
REQ-033 adc=cos=32767, R=4, shift=14 -> i_o=32767 and overflow_o=1; clear_i pulse -> overflow_o=0.
REQ-034 ready_i=0 across two frame dumps -> first result held unchanged, second dropped, overflow_o=1; ready_i=1 -> single transfer of the first result.
REQ-035 decim_i=0, constant inputs -> exactly one output per 256 accepted samples; a decim_i change mid-frame takes effect only from the next frame.
REQ-036 rst_i pulse after 2 of 4 samples -> all outputs 0; the next frame needs 4 new samples and its result excludes pre-reset data.
